c17_misr_checker: RTL and testbench

- Response-side companion to the c17 stimulus driver. It compacts the pipelined c17 outputs (N22, N23) for one full test-vector sweep into a MISR signature.
- At the end of the sweep it compares the signature against a golden value and flags pass/fail.
- It sits beside the c17 DUT, on the same clk, and consumes a per-vector strobe from the stimulus side.

---
 rtl/c17_misr_checker.sv | 216 +++++++++++++++++++++
 tb/tb_c17_misr_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/c17_misr_checker.sv
`default_nettype none
// ============================================================================
// Module   : c17_misr_checker
// Purpose  : Response compactor for the pipelined c17 block. Folds the
//            (N23, N22) pair of every vector in one sweep into a MISR,
//            then compares the final signature with GOLDEN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   system clock, rising edge
//   r        in   asynchronous active-high reset
//   start    in   one-cycle pulse, begins a sweep (ignored while busy)
//   vec_stb  in   one-cycle pulse per vector applied by the stimulus driver
//   n22,n23  in   c17 DUT outputs
//   busy     out  sweep in progress
//   done     out  sweep finished, result valid until the next start
//   pass     out  signature matched GOLDEN and no timeout (valid with done)
//   fail     out  inverse of pass (valid with done)
//   timeout  out  sweep ended because strobes stopped arriving
//   sig      out  current MISR contents
//   vec_cnt  out  responses compacted in this sweep
//   resp_log out  captured response pairs (only with C17_MISR_CAPTURE_EN)
// Optional build macro: C17_MISR_CAPTURE_EN
// ============================================================================
module c17_misr_checker #(
  parameter int               LATENCY = 1,
  parameter int               NUM_VEC = 32,
  parameter int               SIG_W   = 8,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(8'h1D),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(8'hFF),
  parameter logic [SIG_W-1:0] GOLDEN  = SIG_W'(8'h00),
  parameter int               TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic             vec_stb,
  input  logic             n22,
  input  logic             n23,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [SIG_W-1:0] sig,
  output logic [5:0]       vec_cnt
`ifdef C17_MISR_CAPTURE_EN
  ,
  output logic [2*NUM_VEC-1:0] resp_log
`endif
);

  localparam int         c_TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_RUN    = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic [5:0]          vec_cnt_q, vec_cnt_d;
  logic [c_TCNT_W-1:0] tcnt_q, tcnt_d;
  logic                timeout_q, timeout_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;

  logic                start_go;   // start accepted (not in RUN)
  logic                stb_dly;    // vec_stb aligned with the DUT response
  logic [SIG_W-1:0]    misr_next;
  logic                last_stb;
  logic                tmo_hit;

  assign start_go = start & (state_q != c_RUN);

  // Strobe delay line matching the DUT pipeline depth
  generate
    if (LATENCY == 0) begin : g_lat0
      assign stb_dly = vec_stb;
    end else begin : g_latn
      logic [LATENCY-1:0] stb_pipe_q, stb_pipe_d;

      always_comb begin
        stb_pipe_d = (stb_pipe_q << 1) | LATENCY'(vec_stb);
        // strobes from before the sweep must not be counted in it
        if (start_go) stb_pipe_d = '0;
      end

      always_ff @(posedge clk or posedge r) begin
        if (r) stb_pipe_q <= '0;
        else   stb_pipe_q <= stb_pipe_d;
      end

      assign stb_dly = stb_pipe_q[LATENCY-1];
    end
  endgenerate

  // Galois-style MISR step with the response pair injected at the LSBs
  assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'({n23, n22});

  assign last_stb = stb_dly & (vec_cnt_q == 6'(NUM_VEC - 1));
  assign tmo_hit  = ~stb_dly & (tcnt_q == c_TCNT_W'(TIMEOUT - 1));

  // ---- state register ----
  always_ff @(posedge clk or posedge r) begin
    if (r) state_q <= c_IDLE;
    else   state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE, c_DONE: if (start) state_d = c_RUN;
      c_RUN:          if (last_stb || tmo_hit) state_d = c_DONE;
      default:        state_d = c_IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    busy = (state_q == c_RUN);
    done = (state_q == c_DONE);
  end

  // ---- datapath ----
  always_comb begin
    sig_d     = sig_q;
    vec_cnt_d = vec_cnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    case (state_q)
      c_IDLE, c_DONE: begin
        if (start) begin
          sig_d     = SEED;
          vec_cnt_d = '0;
          tcnt_d    = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
        end
      end
      c_RUN: begin
        if (stb_dly) begin
          // a strobe always wins over a coincident timeout
          sig_d  = misr_next;
          tcnt_d = '0;
          if (vec_cnt_q != 6'(NUM_VEC)) vec_cnt_d = vec_cnt_q + 6'd1;
          if (last_stb) begin
            // the final compaction is part of the compare
            pass_d = (misr_next == GOLDEN);
            fail_d = (misr_next != GOLDEN);
          end
        end else begin
          tcnt_d = tcnt_q + c_TCNT_W'(1);
          if (tmo_hit) begin
            timeout_d = 1'b1;
            pass_d    = 1'b0;
            fail_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      sig_q     <= '0;
      vec_cnt_q <= '0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sig_q     <= sig_d;
      vec_cnt_q <= vec_cnt_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign sig     = sig_q;
  assign vec_cnt = vec_cnt_q;
  assign timeout = timeout_q;
  assign pass    = pass_q;
  assign fail    = fail_q;

`ifdef C17_MISR_CAPTURE_EN
  logic [2*NUM_VEC-1:0] resp_log_q, resp_log_d;

  always_comb begin
    resp_log_d = resp_log_q;
    if (start_go) begin
      resp_log_d = '0;
    end else if ((state_q == c_RUN) && stb_dly) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        if (vec_cnt_q == 6'(i)) resp_log_d[2*i +: 2] = {n23, n22};
      end
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) resp_log_q <= '0;
    else   resp_log_q <= resp_log_d;
  end

  assign resp_log = resp_log_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c17_misr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_c17_misr_checker
// Purpose  : Directed bench for c17_misr_checker. Instance A: LATENCY=1,
//            SEED=00. Instance B: LATENCY=3, SEED=FF. Both share clk, reset,
//            start and strobe; each gets its own response lines, changed at
//            the cycle its delayed strobe samples them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c17_misr_checker;

  logic clk = 1'b0;
  logic r   = 1'b1;
  logic start = 1'b0;
  logic vec_stb = 1'b0;
  logic n22_a = 1'b0, n23_a = 1'b0;
  logic n22_b = 1'b0, n23_b = 1'b0;

  logic       busy_a, done_a, pass_a, fail_a, timeout_a;
  logic [7:0] sig_a;
  logic [5:0] vec_cnt_a;
  logic       busy_b, done_b, pass_b, fail_b, timeout_b;
  logic [7:0] sig_b;
  logic [5:0] vec_cnt_b;
`ifdef C17_MISR_CAPTURE_EN
  logic [63:0] resp_log_a, resp_log_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_b   = 0;

  always #5 clk = ~clk;

  c17_misr_checker #(
    .LATENCY(1), .NUM_VEC(32), .SIG_W(8), .POLY(8'h1D),
    .SEED(8'h00), .GOLDEN(8'h00), .TIMEOUT(64)
  ) u_dut_a (
    .clk(clk), .r(r), .start(start), .vec_stb(vec_stb),
    .n22(n22_a), .n23(n23_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
    .timeout(timeout_a), .sig(sig_a), .vec_cnt(vec_cnt_a)
`ifdef C17_MISR_CAPTURE_EN
    , .resp_log(resp_log_a)
`endif
  );

  c17_misr_checker #(
    .LATENCY(3), .NUM_VEC(32), .SIG_W(8), .POLY(8'h1D),
    .SEED(8'hFF), .GOLDEN(8'h00), .TIMEOUT(64)
  ) u_dut_b (
    .clk(clk), .r(r), .start(start), .vec_stb(vec_stb),
    .n22(n22_b), .n23(n23_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
    .timeout(timeout_b), .sig(sig_b), .vec_cnt(vec_cnt_b)
`ifdef C17_MISR_CAPTURE_EN
    , .resp_log(resp_log_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    exp_b = 0;
  endtask

  // One vector: strobe, then each response pair is presented in the cycle
  // its instance samples it (1 clk later for A, 3 clks later for B).
  task automatic send_vec(input logic [1:0] resp, input int gap,
                          input bit chk_b, input bit last);
    @(negedge clk); vec_stb = 1'b1;
    @(negedge clk); vec_stb = 1'b0; {n23_a, n22_a} = resp;
    if (last) check_eq("a_done_before_last", done_a, 0);
    @(negedge clk);
    if (last) begin
      check_eq("a_done_after_last", done_a, 1);
      check_eq("a_cnt_after_last", vec_cnt_a, 32);
    end
    @(negedge clk); {n23_b, n22_b} = resp;
    if (chk_b) check_eq("b_cnt_stb+2", vec_cnt_b, exp_b);
    @(negedge clk);
    if (chk_b) begin
      check_eq("b_cnt_stb+3", vec_cnt_b, exp_b + 1);
      exp_b++;
    end
    repeat (gap - 4) @(negedge clk);
  endtask

  initial begin
    // ---- reset ----
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_pass_fail", {pass_a, fail_a, timeout_a}, 0);
    check_eq("rst_sig_b", sig_b, 0);
    check_eq("rst_cnt_b", vec_cnt_b, 0);
    r = 1'b0;

    // ---- zero sweep ----
    pulse_start();
    check_eq("start_busy", busy_a, 1);
    check_eq("start_sig_b", sig_b, 8'hFF);
    for (int i = 0; i < 32; i++) send_vec(2'b00, 20, 1'b1, i == 31);
    check_eq("zero_sig", sig_a, 8'h00);
    check_eq("zero_pass", pass_a, 1);
    check_eq("zero_fail", fail_a, 0);
    check_eq("zero_tmo", timeout_a, 0);
    check_eq("zero_busy", busy_a, 0);
    check_eq("zero_b_done", done_b, 1);
    check_eq("zero_b_cnt", vec_cnt_b, 32);

    // ---- single-bit error on vector index 5: x^26 mod P = 0x06 ----
    pulse_start();
    for (int i = 0; i < 32; i++)
      send_vec((i == 5) ? 2'b01 : 2'b00, 20, 1'b0, i == 31);
    check_eq("err_sig", sig_a, 8'h06);
    check_eq("err_pass", pass_a, 0);
    check_eq("err_fail", fail_a, 1);

    // ---- latency alignment, then timeout after 4 strobes ----
    pulse_start();
    send_vec(2'b01, 20, 1'b1, 1'b0);
    send_vec(2'b10, 20, 1'b1, 1'b0);
    send_vec(2'b11, 20, 1'b1, 1'b0);
    check_eq("align_sig_b", sig_b, 8'hA8);
    check_eq("align_sig_a", sig_a, 8'h03);
`ifdef C17_MISR_CAPTURE_EN
    check_eq("cap_b", resp_log_b[5:0], 6'b111001);
    check_eq("cap_a", resp_log_a[5:0], 6'b111001);
`endif
    send_vec(2'b00, 20, 1'b1, 1'b0);   // returns after edge P19
    repeat (45) @(negedge clk);        // after P64
    check_eq("tmo_a_early", done_a, 0);
    @(negedge clk);                    // after P65
    check_eq("tmo_a_done", done_a, 1);
    check_eq("tmo_a_flag", timeout_a, 1);
    check_eq("tmo_a_fail", fail_a, 1);
    check_eq("tmo_a_pass", pass_a, 0);
    check_eq("tmo_a_cnt", vec_cnt_a, 4);
    @(negedge clk);                    // after P66
    check_eq("tmo_b_early", done_b, 0);
    @(negedge clk);                    // after P67
    check_eq("tmo_b_done", done_b, 1);
    check_eq("tmo_b_cnt", vec_cnt_b, 4);

    // ---- start ignored in RUN, honoured in DONE ----
    pulse_start();
    send_vec(2'b01, 20, 1'b0, 1'b0);
    send_vec(2'b01, 20, 1'b0, 1'b0);
    pulse_start();
    @(negedge clk);
    check_eq("ign_cnt", vec_cnt_a, 2);
    check_eq("ign_sig", sig_a, 8'h03);
    check_eq("ign_busy", busy_a, 1);
    repeat (80) @(negedge clk);
    check_eq("ign_tmo_done", done_a, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("rs_sig_b", sig_b, 8'hFF);
    check_eq("rs_cnt_b", vec_cnt_b, 0);
    check_eq("rs_busy_b", busy_b, 1);
    check_eq("rs_done_b", done_b, 0);

    // ---- asynchronous reset mid-sweep ----
    exp_b = 0;
    for (int i = 0; i < 10; i++) send_vec(2'b00, 20, 1'b0, 1'b0);
    @(negedge clk);
    #2 r = 1'b1;
    #1;
    check_eq("arst_busy", busy_a, 0);
    check_eq("arst_sig_b", sig_b, 0);
    check_eq("arst_cnt", vec_cnt_a, 0);
    @(negedge clk); r = 1'b0;
    pulse_start();
    for (int i = 0; i < 32; i++) send_vec(2'b00, 20, 1'b0, i == 31);
    check_eq("post_pass", pass_a, 1);
    check_eq("post_cnt", vec_cnt_a, 32);
    check_eq("post_sig", sig_a, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
